// File: rtl/mem_stage.sv
// EX/MEM pipeline register, data-memory access FSM and MEM/WB pipeline register.
// Stalls upstream while a load/store waits on dmem_ready; abandons it after TIMEOUT_CYCLES.
module mem_stage #(
    parameter int WORD_BITWIDTH    = 32,
    parameter int REG_NUM_BITWIDTH = 5,
    parameter int TIMEOUT_CYCLES   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ex_valid,
    input  logic [WORD_BITWIDTH-1:0]    ex_alu_result,
    input  logic [WORD_BITWIDTH-1:0]    ex_store_data,
    input  logic                        ex_mem_read,
    input  logic                        ex_mem_write,
    input  logic                        ex_reg_write,
    input  logic                        ex_mem_to_reg,
    input  logic [REG_NUM_BITWIDTH-1:0] ex_rd,
    input  logic                        flush,
    output logic                        mem_stall,
    output logic                        dmem_req,
    output logic                        dmem_we,
    output logic [WORD_BITWIDTH-1:0]    dmem_addr,
    output logic [WORD_BITWIDTH-1:0]    dmem_wdata,
    input  logic [WORD_BITWIDTH-1:0]    dmem_rdata,
    input  logic                        dmem_ready,
    output logic [WORD_BITWIDTH-1:0]    fd_ex_mem_data,
    output logic [WORD_BITWIDTH-1:0]    fd_mem_wb_data,
    output logic [REG_NUM_BITWIDTH-1:0] exmem_rd,
    output logic                        exmem_reg_write,
    output logic [REG_NUM_BITWIDTH-1:0] memwb_rd,
    output logic                        memwb_reg_write,
    output logic                        wb_valid,
    output logic                        mem_err
);

    localparam int CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WORD_BITWIDTH-1:0] TIMEOUT_DATA = WORD_BITWIDTH'(32'hDEADBEEF);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                      r_state;
    logic [CW-1:0]               r_wait_cnt;
    logic                        r_mem_err;

    logic                        r_exmem_valid;
    logic [WORD_BITWIDTH-1:0]    r_exmem_alu;
    logic [WORD_BITWIDTH-1:0]    r_exmem_store_data;
    logic                        r_exmem_mem_read;
    logic                        r_exmem_mem_write;
    logic                        r_exmem_reg_write;
    logic                        r_exmem_mem_to_reg;
    logic [REG_NUM_BITWIDTH-1:0] r_exmem_rd;

    logic                        r_memwb_valid;
    logic                        r_memwb_reg_write;
    logic [REG_NUM_BITWIDTH-1:0] r_memwb_rd;
    logic [WORD_BITWIDTH-1:0]    r_memwb_data;

    logic                        w_in_valid;
    logic                        w_pending;
    logic                        w_req;
    logic                        w_hs;
    logic [CW-1:0]               w_access_cycle;
    logic                        w_timeout;
    logic                        w_stall;
    logic [WORD_BITWIDTH-1:0]    w_load_data;

    // w_access_cycle numbers the cycles of the current access from 1 (the IDLE
    // cycle); the access is abandoned in its TIMEOUT_CYCLES-th cycle.
    always_comb begin
        w_in_valid     = ex_valid && !flush;
        w_pending      = r_exmem_valid && (r_exmem_mem_read || r_exmem_mem_write);
        w_req          = w_pending && (r_state != S_DONE);
        w_hs           = w_req && dmem_ready;
        w_access_cycle = (r_state == S_WAIT) ? (r_wait_cnt + CW'(1)) : CW'(1);
        w_timeout      = w_req && !dmem_ready && (w_access_cycle == CW'(TIMEOUT_CYCLES));
        w_stall        = w_pending && !w_hs && !w_timeout;
        w_load_data    = w_timeout ? TIMEOUT_DATA : dmem_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            if (w_timeout)
                r_mem_err <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_pending && !dmem_ready && !w_timeout) begin
                        r_state    <= S_WAIT;
                        r_wait_cnt <= CW'(1);
                    end
                end
                S_WAIT: begin
                    if (dmem_ready || w_timeout) begin
                        r_state    <= S_IDLE;
                        r_wait_cnt <= '0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

    // EX/MEM holds while stalled; flush is meaningless then since EX is frozen.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_exmem_valid      <= 1'b0;
            r_exmem_alu        <= '0;
            r_exmem_store_data <= '0;
            r_exmem_mem_read   <= 1'b0;
            r_exmem_mem_write  <= 1'b0;
            r_exmem_reg_write  <= 1'b0;
            r_exmem_mem_to_reg <= 1'b0;
            r_exmem_rd         <= '0;
        end else if (!w_stall) begin
            r_exmem_valid      <= w_in_valid;
            r_exmem_alu        <= ex_alu_result;
            r_exmem_store_data <= ex_store_data;
            r_exmem_mem_read   <= ex_mem_read && w_in_valid;
            r_exmem_mem_write  <= ex_mem_write && w_in_valid;
            r_exmem_reg_write  <= ex_reg_write && w_in_valid;
            r_exmem_mem_to_reg <= ex_mem_to_reg;
            r_exmem_rd         <= ex_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_memwb_valid     <= 1'b0;
            r_memwb_reg_write <= 1'b0;
            r_memwb_rd        <= '0;
            r_memwb_data      <= '0;
        end else if (w_stall) begin
            r_memwb_valid     <= 1'b0;
            r_memwb_reg_write <= 1'b0;
        end else begin
            r_memwb_valid     <= r_exmem_valid;
            r_memwb_reg_write <= r_exmem_reg_write;
            r_memwb_rd        <= r_exmem_rd;
            r_memwb_data      <= r_exmem_mem_to_reg ? w_load_data : r_exmem_alu;
        end
    end

    assign mem_stall       = w_stall;
    assign dmem_req        = w_req;
    assign dmem_we         = r_exmem_mem_write;
    assign dmem_addr       = {r_exmem_alu[WORD_BITWIDTH-1:2], 2'b00};
    assign dmem_wdata      = r_exmem_store_data;
    assign fd_ex_mem_data  = r_exmem_alu;
    assign fd_mem_wb_data  = r_memwb_data;
    assign exmem_rd        = r_exmem_rd;
    assign exmem_reg_write = r_exmem_reg_write;
    assign memwb_rd        = r_memwb_rd;
    assign memwb_reg_write = r_memwb_reg_write;
    assign wb_valid        = r_memwb_valid;
    assign mem_err         = r_mem_err;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: random instruction stream plus a data memory
// with per-access latency; expected write-back results come from a behavioural model.
module tb_mem_stage;

    localparam int W = 32;
    localparam int R = 5;
    localparam int T = 6;

    logic         clk = 1'b0;
    logic         rst;
    logic         ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, flush;
    logic [W-1:0] ex_alu_result, ex_store_data;
    logic [R-1:0] ex_rd;
    logic         mem_stall, dmem_req, dmem_we, dmem_ready;
    logic [W-1:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [W-1:0] fd_ex_mem_data, fd_mem_wb_data;
    logic [R-1:0] exmem_rd, memwb_rd;
    logic         exmem_reg_write, memwb_reg_write, wb_valid, mem_err;

    mem_stage #(.WORD_BITWIDTH(W), .REG_NUM_BITWIDTH(R), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_alu_result(ex_alu_result),
        .ex_store_data(ex_store_data), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_rd(ex_rd),
        .flush(flush), .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .dmem_ready(dmem_ready), .fd_ex_mem_data(fd_ex_mem_data), .fd_mem_wb_data(fd_mem_wb_data),
        .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .memwb_rd(memwb_rd),
        .memwb_reg_write(memwb_reg_write), .wb_valid(wb_valid), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    // kind: 0 = ALU op, 1 = load, 2 = store; k = not-ready cycles before the memory answers
    typedef struct {
        bit           valid;
        bit           flush;
        int unsigned  kind;
        logic [W-1:0] alu;
        logic [W-1:0] sd;
        logic [R-1:0] rd;
        int unsigned  k;
        logic [W-1:0] rdata;
    } ins_t;

    typedef struct {
        logic [R-1:0] rd;
        logic         rw;
        logic [W-1:0] data;
        logic         err;
    } wb_t;

    typedef struct {
        int unsigned  k;
        logic [W-1:0] addr;
        logic         we;
        logic [W-1:0] wdata;
        logic [W-1:0] rdata;
    } acc_t;

    wb_t  wb_q[$];
    acc_t acc_q[$];
    ins_t dir_q[$];

    int total = 0;
    int bad   = 0;

    bit           mon_en = 0;
    bit           err_m = 0;
    int           exp_stalls = 0, seen_stalls = 0, n_rand = 0;
    logic [W-1:0] exp_fd = '0;
    logic [R-1:0] exp_ex_rd = '0;
    logic         exp_ex_rw = 1'b0;
    ins_t         cur;
    bit           have_cur = 0;
    bit           active = 0;
    int unsigned  cnt = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ins_t mk(input bit v, input bit fl, input int unsigned kind,
                                input logic [W-1:0] alu, input logic [W-1:0] sd,
                                input logic [R-1:0] rd, input int unsigned k,
                                input logic [W-1:0] rdata);
        ins_t i;
        i.valid = v; i.flush = fl; i.kind = kind; i.alu = alu; i.sd = sd;
        i.rd = rd; i.k = k; i.rdata = rdata;
        return i;
    endfunction

    function automatic ins_t rand_ins();
        int unsigned r;
        int unsigned k;
        r = $urandom_range(0, 9);
        if (r < 4)      k = 0;
        else if (r < 8) k = $urandom_range(1, T - 1);
        else            k = $urandom_range(T, T + 3);
        return mk(($urandom % 8) != 0, ($urandom % 6) == 0, $urandom_range(0, 2),
                  $urandom, $urandom, R'($urandom), k, $urandom);
    endfunction

    task automatic apply(input ins_t i);
        ex_valid      = i.valid;
        flush         = i.flush;
        ex_alu_result = i.alu;
        ex_store_data = i.sd;
        ex_rd         = i.rd;
        ex_mem_read   = (i.kind == 1);
        ex_mem_write  = (i.kind == 2);
        ex_reg_write  = (i.kind != 2);
        ex_mem_to_reg = (i.kind == 1);
    endtask

    // One clock cycle: memory answers, EX presents, model records what gets captured.
    task automatic step();
        bit   eff, tmo;
        acc_t a;
        wb_t  e;
        @(negedge clk);
        if (dmem_req) begin
            if (acc_q.size() == 0) begin
                check("unexpected_req", W'(dmem_req), W'(0));
                dmem_ready = 1'b1;
            end else begin
                if (!active) begin
                    active = 1;
                    cnt = 0;
                end
                dmem_ready = (cnt == acc_q[0].k);
                dmem_rdata = acc_q[0].rdata;
            end
        end else begin
            dmem_ready = 1'($urandom_range(0, 1));
            dmem_rdata = $urandom;
        end
        if (!have_cur) begin
            if (dir_q.size() > 0)  cur = dir_q.pop_front();
            else if (n_rand > 0) begin
                cur = rand_ins();
                n_rand--;
            end else cur = mk(0, 0, 0, $urandom, $urandom, R'($urandom), 0, 0);
            apply(cur);
            have_cur = 1;
        end
        #1;
        if (active && dmem_req && dmem_ready) begin
            check("dmem_addr", dmem_addr, acc_q[0].addr);
            check("dmem_we", W'(dmem_we), W'(acc_q[0].we));
            if (acc_q[0].we) check("dmem_wdata", dmem_wdata, acc_q[0].wdata);
        end
        if (mem_stall) seen_stalls++;
        if (!mem_stall) begin
            eff = cur.valid && !cur.flush;
            exp_fd    = cur.alu;
            exp_ex_rd = cur.rd;
            exp_ex_rw = eff && (cur.kind != 2);
            if (eff) begin
                tmo = 0;
                if (cur.kind != 0) begin
                    tmo = (cur.k >= T);
                    a.k = cur.k;
                    a.addr = cur.alu & ~W'(3);
                    a.we = (cur.kind == 2);
                    a.wdata = cur.sd;
                    a.rdata = cur.rdata;
                    acc_q.push_back(a);
                    exp_stalls += tmo ? (T - 1) : int'(cur.k);
                    if (tmo) err_m = 1;
                end
                e.rd   = cur.rd;
                e.rw   = (cur.kind != 2);
                e.data = (cur.kind == 1) ? (tmo ? 32'hDEADBEEF : cur.rdata) : cur.alu;
                e.err  = err_m;
                wb_q.push_back(e);
            end
            have_cur = 0;
        end
        if (active) begin
            if (dmem_ready) begin
                active = 0;
                void'(acc_q.pop_front());
            end else begin
                cnt++;
                if (cnt == T) begin
                    active = 0;
                    void'(acc_q.pop_front());
                end
            end
        end
    endtask

    always @(posedge clk) begin
        wb_t e;
        #1;
        if (mon_en) begin
            check("exmem_fd", fd_ex_mem_data, exp_fd);
            check("exmem_rd", W'(exmem_rd), W'(exp_ex_rd));
            check("exmem_reg_write", W'(exmem_reg_write), W'(exp_ex_rw));
            if (wb_valid) begin
                if (wb_q.size() == 0) begin
                    check("wb_unexpected", W'(wb_valid), W'(0));
                end else begin
                    e = wb_q.pop_front();
                    check("wb_data", fd_mem_wb_data, e.data);
                    check("wb_rd", W'(memwb_rd), W'(e.rd));
                    check("wb_reg_write", W'(memwb_reg_write), W'(e.rw));
                    check("mem_err", W'(mem_err), W'(e.err));
                end
            end else begin
                check("bubble_reg_write", W'(memwb_reg_write), W'(0));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        int guard;
        rst = 1'b1;
        apply(mk(0, 0, 0, '0, '0, '0, 0, '0));
        dmem_ready = 1'b0;
        dmem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req", W'(dmem_req), W'(0));
        check("rst_stall", W'(mem_stall), W'(0));
        check("rst_wb_valid", W'(wb_valid), W'(0));
        check("rst_mem_err", W'(mem_err), W'(0));
        check("rst_fd_ex_mem", fd_ex_mem_data, W'(0));
        check("rst_fd_mem_wb", fd_mem_wb_data, W'(0));
        check("rst_exmem_rw", W'(exmem_reg_write), W'(0));
        check("rst_memwb_rw", W'(memwb_reg_write), W'(0));
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1;

        dir_q.push_back(mk(1, 0, 0, 32'h10, '0, 5'd5, 0, '0));                  // ADD x5
        dir_q.push_back(mk(1, 0, 1, 32'h104, '0, 5'd6, 0, 32'hCAFEF00D));        // LD, ready at once
        dir_q.push_back(mk(1, 0, 2, 32'h203, 32'h55, 5'd0, 3, '0));              // ST, 3 wait cycles
        dir_q.push_back(mk(1, 1, 0, 32'h77, '0, 5'd7, 0, '0));                   // flushed ADD
        dir_q.push_back(mk(1, 0, 1, 32'h400, '0, 5'd8, T - 1, 32'h12345678));    // ready in timeout cycle
        dir_q.push_back(mk(1, 0, 1, 32'h500, '0, 5'd9, 1000, 32'h0BADF00D));     // never ready
        n_rand = 300;
        while (dir_q.size() > 0 || n_rand > 0) step();

        guard = 0;
        while ((wb_q.size() != 0 || acc_q.size() != 0) && guard < 400) begin
            step();
            guard++;
        end
        check("drain_done", W'(wb_q.size() + acc_q.size()), W'(0));
        check("stall_cycles", W'(seen_stalls), W'(exp_stalls));

        // Reset during the second WAIT cycle of a load that never completes.
        @(negedge clk);
        mon_en = 0;
        dmem_ready = 1'b0;
        apply(mk(1, 0, 1, 32'h300, '0, 5'd3, 0, '0));
        @(negedge clk);
        apply(mk(0, 0, 0, '0, '0, '0, 0, '0));
        dmem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("wait2_req", W'(dmem_req), W'(1));
        check("wait2_stall", W'(mem_stall), W'(1));
        check("wait2_mem_err", W'(mem_err), W'(1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rstwait_req", W'(dmem_req), W'(0));
        check("rstwait_stall", W'(mem_stall), W'(0));
        check("rstwait_wb_valid", W'(wb_valid), W'(0));
        check("rstwait_mem_err", W'(mem_err), W'(0));
        rst = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
